// File: rtl/gbuff_arbiter_if.sv
// Requester-side and global-buffer-side signals of gbuff_arbiter.
// slave is the arbiter's view; master is the view of the surrounding engines and buffer.
`ifndef GBUFF_INDX_SIZE
`define GBUFF_INDX_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface gbuff_arbiter_if #(
  parameter int unsigned IDX_W  = `GBUFF_INDX_SIZE,
  parameter int unsigned WORD_W = `WORD_SIZE,
  parameter int unsigned LEN_W  = 8
);
  logic [2:0]          req;
  logic [2:0]          req_wr;
  logic [3*IDX_W-1:0]  req_base;
  logic [3*LEN_W-1:0]  req_len;
  logic [3*WORD_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          beat_ack;
  logic [2:0]          done;
  logic [WORD_W-1:0]   rdata;
  logic [2:0]          rvalid;
  logic                gb_wr_en;
  logic [IDX_W-1:0]    gb_index;
  logic [WORD_W-1:0]   gb_data_in;
  logic [WORD_W-1:0]   gb_data_out;

  modport master (
    output req, req_wr, req_base, req_len, wdata, gb_data_out,
    input  gnt, beat_ack, done, rdata, rvalid, gb_wr_en, gb_index, gb_data_in
  );

  modport slave (
    input  req, req_wr, req_base, req_len, wdata, gb_data_out,
    output gnt, beat_ack, done, rdata, rvalid, gb_wr_en, gb_index, gb_data_in
  );
endinterface

// File: rtl/gbuff_arbiter.sv
// Round-robin burst arbiter sharing the single-port global buffer among three requesters,
// with per-burst auto-incrementing addresses and tagged read return.
`ifndef GBUFF_INDX_SIZE
`define GBUFF_INDX_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module gbuff_arbiter #(
  parameter int unsigned IDX_W  = `GBUFF_INDX_SIZE,
  parameter int unsigned WORD_W = `WORD_SIZE,
  parameter int unsigned LEN_W  = 8
) (
  input logic            clk,
  input logic            rst,
  gbuff_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         own_q, own_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         rvalid_q, rvalid_d;

  logic [1:0]         cand1, cand2, winner;
  logic [2:0]         own_oh;
  logic               last_beat;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search order is last+1, last+2, then last itself.
  always_comb begin
    cand1 = next_port(last_q);
    cand2 = next_port(cand1);
    if (bus.req[cand1])      winner = cand1;
    else if (bus.req[cand2]) winner = cand2;
    else                     winner = last_q;
  end

  assign own_oh    = 3'b001 << own_q;
  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= 2'd2;
      own_q    <= 2'd0;
      wr_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 3'b000;
    end else begin
      last_q   <= last_d;
      own_q    <= own_d;
      wr_q     <= wr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    wr_d     = wr_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rvalid_d = 3'b000;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StBurst;
          last_d  = winner;
          own_d   = winner;
          wr_d    = bus.req_wr[winner];
          base_d  = bus.req_base[int'(winner)*IDX_W +: IDX_W];
          len_d   = bus.req_len[int'(winner)*LEN_W +: LEN_W];
          cnt_d   = '0;
        end
      end
      StBurst: begin
        // Registered to line up with the buffer's one-cycle read.
        rvalid_d = wr_q ? 3'b000 : own_oh;
        if (last_beat) state_d = StIdle;
        else           cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.gnt        = 3'b000;
    bus.beat_ack   = 3'b000;
    bus.done       = 3'b000;
    bus.gb_wr_en   = 1'b0;
    bus.gb_index   = '0;
    bus.gb_data_in = '0;
    if (state_q == StBurst) begin
      bus.gnt      = own_oh;
      bus.beat_ack = own_oh;
      bus.done     = last_beat ? own_oh : 3'b000;
      bus.gb_wr_en = wr_q;
      bus.gb_index = base_q + IDX_W'(cnt_q);
      if (wr_q) bus.gb_data_in = bus.wdata[int'(own_q)*WORD_W +: WORD_W];
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = bus.gb_data_out;

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Scoreboard bench for gbuff_arbiter: stimulus pushes expected beats and read returns,
// a negedge monitor pops and compares them; a behavioural buffer closes the loop.
module tb_gbuff_arbiter;
  localparam int IDX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 1 << IDX_W;

  typedef struct packed {
    logic [2:0]        gnt;
    logic [IDX_W-1:0]  idx;
    logic              wr;
    logic [WORD_W-1:0] data;
    logic [2:0]        done;
  } beat_t;

  typedef struct packed {
    logic [2:0]        port;
    logic [WORD_W-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gbuff_arbiter_if #(.IDX_W(IDX_W), .WORD_W(WORD_W), .LEN_W(LEN_W)) bus ();

  gbuff_arbiter #(.IDX_W(IDX_W), .WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port buffer with registered read.
  logic [WORD_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.gb_wr_en) mem[bus.gb_index] <= bus.gb_data_in;
    bus.gb_data_out <= mem[bus.gb_index];
  end

  logic [WORD_W-1:0] mdl [DEPTH];
  beat_t beat_q[$];
  rd_t   rd_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    sb_en    = 1'b0;
  logic  prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      if (prev_done) check("idle_gap", 64'(bus.beat_ack), 64'd0);
      if (bus.beat_ack != 3'b000) begin
        beat_t act, exp;
        act = '{gnt: bus.gnt, idx: bus.gb_index, wr: bus.gb_wr_en,
                data: bus.gb_data_in, done: bus.done};
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 64'(bus.beat_ack), 64'd0);
        end else begin
          exp = beat_q.pop_front();
          check("beat", 64'(act), 64'(exp));
        end
      end
      if (bus.rvalid != 3'b000) begin
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 64'(bus.rvalid), 64'd0);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          check("read", {29'd0, bus.rvalid, bus.rdata}, 64'(r));
        end
      end
      prev_done <= |bus.done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic push_beat(input int p, input bit wr, input int base, input int k, input int len,
                           input logic [WORD_W-1:0] w);
    beat_t b;
    int    a;
    a = (base + k) % DEPTH;
    b.gnt  = 3'(1 << p);
    b.idx  = IDX_W'(a);
    b.wr   = wr;
    b.data = wr ? w : '0;
    b.done = (k == len) ? 3'(1 << p) : 3'b000;
    beat_q.push_back(b);
    if (wr) mdl[a] = w;
    else rd_q.push_back('{port: 3'(1 << p), data: mdl[a]});
  endtask

  task automatic set_port(input int p, input bit wr, input int base, input int len,
                          input logic [WORD_W-1:0] w);
    bus.req_wr[p]                    = wr;
    bus.req_base[p*IDX_W +: IDX_W]   = IDX_W'(base);
    bus.req_len[p*LEN_W +: LEN_W]    = LEN_W'(len);
    bus.wdata[p*WORD_W +: WORD_W]    = w;
  endtask

  task automatic run_burst(input int p, input bit wr, input int base, input int len,
                           input logic [WORD_W-1:0] w0, input int drop_k);
    bit got = 1'b0;
    @(posedge clk); #1;
    set_port(p, wr, base, len, w0);
    bus.req[p] = 1'b1;
    for (int k = 0; k <= len; k++) push_beat(p, wr, base, k, len, w0 + WORD_W'(k));
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.gnt[p];
    end
    check("grant_seen", 64'(got), 64'd1);
    if (!got) begin
      bus.req[p] = 1'b0;
      return;
    end
    for (int k = 0; k <= len; k++) begin
      if (k == drop_k) bus.req[p] = 1'b0;
      @(posedge clk); #1;
      bus.wdata[p*WORD_W +: WORD_W] = w0 + WORD_W'(k + 1);
      if (k < len) @(negedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},      64'(bus.gnt),      64'd0);
    check({tag, "_beat_ack"}, 64'(bus.beat_ack), 64'd0);
    check({tag, "_done"},     64'(bus.done),     64'd0);
    check({tag, "_rvalid"},   64'(bus.rvalid),   64'd0);
    check({tag, "_wr_en"},    64'(bus.gb_wr_en), 64'd0);
    check({tag, "_index"},    64'(bus.gb_index), 64'd0);
  endtask

  initial begin
    int ndone;
    bit got;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    bus.req = '0; bus.req_wr = '0; bus.req_base = '0; bus.req_len = '0; bus.wdata = '0;

    // Reset then single write burst from port 2.
    repeat (2) @(posedge clk);
    #1 check_quiet("reset");
    @(negedge clk); rst = 1'b1;
    sb_en = 1'b1;
    run_burst(2, 1'b1, 10, 3, 32'hA0, 0);

    // Read-back by port 0.
    run_burst(0, 1'b0, 10, 3, 32'h0, 0);

    // Round-robin fairness after a fresh reset.
    @(posedge clk); #1 rst = 1'b0;
    #1 rst = 1'b1;
    set_port(0, 1'b1, 20, 0, 32'hB0);
    set_port(1, 1'b1, 30, 0, 32'hB1);
    set_port(2, 1'b1, 40, 0, 32'hB2);
    for (int r = 0; r < 2; r++) begin
      push_beat(0, 1'b1, 20, 0, 0, 32'hB0);
      push_beat(1, 1'b1, 30, 0, 0, 32'hB1);
      push_beat(2, 1'b1, 40, 0, 0, 32'hB2);
    end
    bus.req = 3'b111;
    ndone = 0;
    for (int i = 0; i < 40 && ndone < 6; i++) begin
      @(negedge clk);
      if (|bus.done) ndone++;
    end
    #1 bus.req = 3'b000;
    check("rr_done_count", 64'(ndone), 64'd6);
    repeat (3) @(posedge clk);

    // Index wrap on port 1, then read it back on port 2.
    run_burst(1, 1'b1, DEPTH - 2, 3, 32'hC0, 0);
    run_burst(2, 1'b0, DEPTH - 2, 3, 32'h0, 0);

    // Port 1 drops req mid-burst; all six beats still issue.
    run_burst(1, 1'b1, 50, 5, 32'hD0, 2);

    check("beat_q_drained", 64'(beat_q.size()), 64'd0);
    check("rd_q_drained",   64'(rd_q.size()),   64'd0);

    // Reset during the 2nd beat of a long read; port 0 must win first afterwards.
    sb_en = 1'b0;
    @(posedge clk); #1;
    set_port(0, 1'b0, 10, 7, 32'h0);
    bus.req = 3'b001;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.gnt[0];
    end
    check("abort_grant_seen", 64'(got), 64'd1);
    bus.req = 3'b000;
    @(negedge clk);
    check("abort_2nd_beat", 64'(bus.beat_ack), 64'd1);
    #1 rst = 1'b0;
    #1 check_quiet("abort");
    set_port(0, 1'b1, 60, 0, 32'hE0);
    set_port(1, 1'b1, 61, 0, 32'hE1);
    set_port(2, 1'b1, 62, 0, 32'hE2);
    bus.req = 3'b111;
    @(negedge clk); rst = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = |bus.gnt;
    end
    bus.req = 3'b000;
    check("post_abort_gnt", 64'(bus.gnt), 64'd1);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
